// File: rtl/nvme_cq_poster.sv
// NVMe completion-queue poster: phase insertion, host address generation, per-queue head/tail tracking.
// Optional interrupt request/ack ports are built only when NVME_CQ_IRQ_EN is defined.
module nvme_cq_poster #(
    parameter int CQ_COUNT = 4,
    parameter int CQ_DEPTH = 64,
    localparam int QID_W = $clog2(CQ_COUNT),
    localparam int PTR_W = $clog2(CQ_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CQ_COUNT-1:0] cq_enable,
    input  logic                cfg_we,
    input  logic [QID_W-1:0]    cfg_qid,
    input  logic [63:0]         cfg_base,
    input  logic                cpl_valid,
    output logic                cpl_ready,
    input  logic [QID_W-1:0]    cpl_qid,
    input  logic [127:0]        cpl_data,
    output logic                cpl_drop,
    output logic                wr_req,
    input  logic                wr_ack,
    output logic [63:0]         wr_addr,
    output logic [127:0]        wr_data,
    output logic [QID_W-1:0]    wr_qid,
`ifdef NVME_CQ_IRQ_EN
    output logic [CQ_COUNT-1:0] irq_req,
    input  logic [CQ_COUNT-1:0] irq_ack,
`endif
    input  logic                dbell_valid,
    input  logic [QID_W-1:0]    dbell_qid,
    input  logic [31:0]         dbell_head,
    output logic                dbell_err,
    output logic [CQ_COUNT-1:0] cq_full,
    output logic [CQ_COUNT-1:0] cq_empty
);

    // state  | meaning
    // IDLE   | waiting for a completion entry
    // WRITE  | memory write outstanding, outputs held until wr_ack
    typedef enum logic {S_IDLE, S_WRITE} state_t;

    localparam logic [31:0] DEPTH32 = 32'(CQ_DEPTH);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    head_q [CQ_COUNT];
    logic [PTR_W-1:0]    tail_q [CQ_COUNT];
    logic [63:0]         base_q [CQ_COUNT];
    logic [CQ_COUNT-1:0] phase_q;
    logic [CQ_COUNT-1:0] en_q;
    logic [CQ_COUNT-1:0] en_fall;
    logic                abort_q;
    logic                accept;
    logic                accept_wr;
    logic                ack_fire;
    logic                dbell_ok;

    assign en_fall  = en_q & ~cq_enable;
    assign dbell_ok = dbell_valid && (dbell_head < DEPTH32);

    always_comb begin
        cq_full  = '0;
        cq_empty = '0;
        for (int q = 0; q < CQ_COUNT; q++) begin
            cq_full[q]  = ((tail_q[q] + PTR_W'(1)) == head_q[q]);
            cq_empty[q] = (tail_q[q] == head_q[q]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // cpl_ready is gated by reset so nothing is offered as accepted while in reset
    always_comb begin
        state_d   = state_q;
        cpl_ready = 1'b0;
        wr_req    = 1'b0;
        ack_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cpl_ready = reset_n & (~cq_full[cpl_qid] | ~cq_enable[cpl_qid]);
                if (cpl_valid && cpl_ready && cq_enable[cpl_qid]) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_req = 1'b1;
                if (wr_ack) begin
                    ack_fire = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept    = (state_q == S_IDLE) && cpl_valid && cpl_ready;
    assign accept_wr = accept && cq_enable[cpl_qid];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_qid    <= '0;
            cpl_drop  <= 1'b0;
            dbell_err <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            cpl_drop  <= accept && !cq_enable[cpl_qid];
            dbell_err <= dbell_valid && (dbell_head >= DEPTH32);
            if (accept_wr) begin
                wr_addr      <= base_q[cpl_qid] + {{(60-PTR_W){1'b0}}, tail_q[cpl_qid], 4'b0};
                wr_data      <= cpl_data;
                wr_data[112] <= phase_q[cpl_qid];
                wr_qid       <= cpl_qid;
                abort_q      <= 1'b0;
            end else if (state_q == S_WRITE && en_fall[wr_qid]) begin
                abort_q <= 1'b1;
            end
        end
    end

    // A queue disabled during its own write still finishes the write but must not advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '1;
            en_q    <= '0;
            for (int q = 0; q < CQ_COUNT; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
                base_q[q] <= '0;
            end
        end else begin
            en_q <= cq_enable;
            for (int q = 0; q < CQ_COUNT; q++) begin
                if (cfg_we && cfg_qid == QID_W'(q))
                    base_q[q] <= cfg_base & ~64'hFFF;
                if (en_fall[q]) begin
                    head_q[q]  <= '0;
                    tail_q[q]  <= '0;
                    phase_q[q] <= 1'b1;
                end else begin
                    if (dbell_ok && dbell_qid == QID_W'(q))
                        head_q[q] <= dbell_head[PTR_W-1:0];
                    if (ack_fire && !abort_q && wr_qid == QID_W'(q)) begin
                        tail_q[q] <= tail_q[q] + PTR_W'(1);
                        if (tail_q[q] == {PTR_W{1'b1}}) phase_q[q] <= ~phase_q[q];
                    end
                end
            end
        end
    end

`ifdef NVME_CQ_IRQ_EN
    logic [CQ_COUNT-1:0] irq_set;

    always_comb begin
        irq_set = '0;
        for (int q = 0; q < CQ_COUNT; q++)
            irq_set[q] = ack_fire && (wr_qid == QID_W'(q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq_req <= '0;
        else          irq_req <= (irq_req & ~irq_ack) | irq_set;
    end
`endif

endmodule

// File: tb/tb_nvme_cq_poster.sv
// Directed bench for nvme_cq_poster: stimulus pushes expected writes, a monitor acks and compares them.
module tb_nvme_cq_poster;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   cq_enable;
    logic         cfg_we;
    logic [1:0]   cfg_qid;
    logic [63:0]  cfg_base;
    logic         cpl_valid;
    logic         cpl_ready;
    logic [1:0]   cpl_qid;
    logic [127:0] cpl_data;
    logic         cpl_drop;
    logic         wr_req;
    logic         wr_ack;
    logic [63:0]  wr_addr;
    logic [127:0] wr_data;
    logic [1:0]   wr_qid;
    logic         dbell_valid;
    logic [1:0]   dbell_qid;
    logic [31:0]  dbell_head;
    logic         dbell_err;
    logic [3:0]   cq_full;
    logic [3:0]   cq_empty;
`ifdef NVME_CQ_IRQ_EN
    logic [3:0]   irq_req;
    logic [3:0]   irq_ack;
`endif

    always #5 clk = ~clk;

    nvme_cq_poster #(.CQ_COUNT(4), .CQ_DEPTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .cq_enable(cq_enable),
        .cfg_we(cfg_we), .cfg_qid(cfg_qid), .cfg_base(cfg_base),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_qid(cpl_qid),
        .cpl_data(cpl_data), .cpl_drop(cpl_drop),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data), .wr_qid(wr_qid),
`ifdef NVME_CQ_IRQ_EN
        .irq_req(irq_req), .irq_ack(irq_ack),
`endif
        .dbell_valid(dbell_valid), .dbell_qid(dbell_qid), .dbell_head(dbell_head),
        .dbell_err(dbell_err), .cq_full(cq_full), .cq_empty(cq_empty)
    );

    typedef struct packed {
        logic [63:0]  addr;
        logic [127:0] data;
        logic [1:0]   qid;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    int          ack_delay = 0;
    int          writes_seen = 0;
    int          writes_pushed = 0;
    logic [63:0] m_base [4];
    int          m_tail [4];
    logic        m_phase[4];

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Monitor: acks writes after ack_delay cycles and checks them against the scoreboard
    initial begin
        exp_t cur;
        bit   in_write;
        int   cnt;
        cur = '0;
        in_write = 0;
        cnt = 0;
        wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req) begin
                if (!in_write) begin
                    in_write = 1;
                    cnt = 0;
                    writes_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: got addr %0h qid %0d expected no write", wr_addr, wr_qid);
                        cur = {wr_addr, wr_data, wr_qid};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("write_entry", {wr_addr, wr_data, wr_qid}, cur);
                    end
                end else begin
                    chk("write_stable", {wr_addr, wr_data, wr_qid}, cur);
                end
                if (cnt >= ack_delay) wr_ack = 1'b1;
                cnt++;
            end else begin
                in_write = 0;
                wr_ack = 1'b0;
            end
        end
    end

    task automatic send_cpl(input int q, input logic [127:0] d);
        int n;
        @(negedge clk);
        cpl_valid = 1'b1;
        cpl_qid   = 2'(q);
        cpl_data  = d;
        n = 0;
        while (!cpl_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cpl_ready) begin
            checks++;
            $display("FAIL cpl_ready_timeout: got 0 expected 1 (q%0d)", q);
            cpl_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cpl_valid = 1'b0;
    endtask

    task automatic post(input int q, input logic [127:0] d);
        exp_t e;
        e.addr = m_base[q] + 64'(m_tail[q]) * 64'd16;
        e.data = d;
        e.data[112] = m_phase[q];
        e.qid = 2'(q);
        exp_q.push_back(e);
        writes_pushed++;
        m_tail[q] = (m_tail[q] + 1) % 64;
        if (m_tail[q] == 0) m_phase[q] = ~m_phase[q];
        send_cpl(q, d);
    endtask

    task automatic cfg(input int q, input logic [63:0] b);
        @(negedge clk);
        cfg_we = 1'b1; cfg_qid = 2'(q); cfg_base = b;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic dbell(input int q, input logic [31:0] h);
        @(negedge clk);
        dbell_valid = 1'b1; dbell_qid = 2'(q); dbell_head = h;
        @(posedge clk);
        #1 dbell_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((wr_req || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (wr_req || exp_q.size() != 0) begin
            checks++;
            $display("FAIL idle_timeout: got wr_req %0d pending %0d expected idle", wr_req, exp_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0; cq_enable = 4'b0; cfg_we = 1'b0; cfg_qid = '0; cfg_base = '0;
        cpl_valid = 1'b0; cpl_qid = '0; cpl_data = '0;
        dbell_valid = 1'b0; dbell_qid = '0; dbell_head = '0;
`ifdef NVME_CQ_IRQ_EN
        irq_ack = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            m_base[i] = '0; m_tail[i] = 0; m_phase[i] = 1'b1;
        end

        repeat (2) @(negedge clk);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_cpl_ready", cpl_ready, 0);
        chk("rst_cq_empty", cq_empty, 4'hF);
        chk("rst_cq_full", cq_full, 4'h0);
        chk("rst_wr_addr", wr_addr, 0);

        @(negedge clk);
        reset_n = 1'b1;
        cq_enable = 4'b1011;

        // Low 12 address bits written here must be discarded
        cfg(1, 64'h0000_0000_1000_0ABC); m_base[1] = 64'h0000_0000_1000_0000;
        cfg(0, 64'h0000_0002_0000_0000); m_base[0] = 64'h0000_0002_0000_0000;
        cfg(3, 64'h0000_0000_4000_0000); m_base[3] = 64'h0000_0000_4000_0000;

        post(1, 128'h0);
        post(1, 128'hCAFE_0001_0000_0002_0000_0003_0000_0004);
        wait_idle();

        for (int i = 0; i < 63; i++) post(0, {96'h0, 32'(i)});
        wait_idle();
        chk("q0_full_after_63", cq_full[0], 1);
        chk("q0_ready_when_full", cpl_ready, 0);
        cpl_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("q0_stall_no_req", wr_req, 0);
        cpl_valid = 1'b0;

        dbell(0, 32'd5);
        @(negedge clk);
        chk("q0_not_full_dbell", cq_full[0], 0);
        chk("q0_ready_after_dbell", cpl_ready, 1);

        post(0, 128'h1234_5678_0000_0000_0000_0000_0000_0063);
        post(0, 128'h1235_5678_0000_0000_0000_0000_0000_0064);
        wait_idle();
        chk("q0_not_empty_wrapped", cq_empty[0], 0);

        dbell(0, 32'd64);
        @(negedge clk);
        chk("dbell_err_pulse", dbell_err, 1);
        @(negedge clk);
        chk("dbell_err_clear", dbell_err, 0);

        // head still 5: tail 1 -> 4 must fill the queue
        for (int i = 0; i < 3; i++) post(0, {96'h0, 32'(100 + i)});
        wait_idle();
        chk("q0_full_head_kept", cq_full[0], 1);
        dbell(0, 32'd4);
        @(negedge clk);
        chk("q0_empty_after_dbell", cq_empty[0], 1);
        chk("q0_full_clear", cq_full[0], 0);

        send_cpl(2, 128'hDEAD);
        @(negedge clk);
        chk("drop_pulse", cpl_drop, 1);
        chk("drop_no_req", wr_req, 0);
        @(negedge clk);
        chk("drop_clear", cpl_drop, 0);

        ack_delay = 10;
        post(1, 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666);
        cfg(1, 64'h0000_0000_3000_0000);
        m_base[1] = 64'h0000_0000_3000_0000;
        wait_idle();
`ifdef NVME_CQ_IRQ_EN
        chk("irq_set_q1", irq_req[1], 1);
        @(negedge clk); irq_ack = 4'b0010;
        @(negedge clk); irq_ack = 4'b0000;
        chk("irq_clear_q1", irq_req[1], 0);
`endif
        ack_delay = 0;
        post(1, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
        wait_idle();

        post(3, 128'h3);
        ack_delay = 5;
        post(3, 128'h33);
        @(negedge clk);
        cq_enable[3] = 1'b0;
        wait_idle();
        m_tail[3] = 0;
        m_phase[3] = 1'b1;
        chk("q3_empty_after_disable", cq_empty[3], 1);
        cq_enable[3] = 1'b1;
        ack_delay = 0;
        post(3, 128'h333);
        wait_idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        chk("write_count", 32'(writes_seen), 32'(writes_pushed));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
